circular_dma_reader: RTL and testbench

//  MM2S counterpart of the circular S2MM DMA: drains a circular buffer in memory over AXI4 read

---
 rtl/circular_dma_reader_if.sv | 40 ++++
 rtl/circular_dma_reader.sv | 117 +++++++++++
 tb/tb_circular_dma_reader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/circular_dma_reader_if.sv
// AXI4 read-address/read-data channels plus the AXI-Stream output of the circular DMA reader.
// master = the DMA engine, slave = the memory/stream side it talks to.
interface circular_dma_reader_if #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_AXIS_WIDTH = 64
);
  logic [C_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [C_AXIS_WIDTH-1:0] m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic [C_AXIS_WIDTH-1:0] m_axis_tdata;
  logic                    m_axis_tlast;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/circular_dma_reader.sv
// Drains a circular memory buffer between rd_offset and wr_offset as AXI4 read bursts onto AXI-Stream.
// Latency: launch decision 1 cycle after IDLE, R->stream beats are combinational passthrough.
// Backpressure: bursts wait for enough downstream fifo_space; in DATA, tready drives rready directly.
module circular_dma_reader #(
  parameter int C_ADDR_WIDTH       = 32,
  parameter int C_AXIS_WIDTH       = 64,
  parameter int C_MAX_BURST        = 16,
  parameter int C_FIFO_SPACE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_enable,
  input  logic [C_ADDR_WIDTH-1:0]       cfg_base,
  input  logic [C_ADDR_WIDTH-1:0]       cfg_size,
  input  logic [C_ADDR_WIDTH-1:0]       wr_offset,
  input  logic [C_FIFO_SPACE_WIDTH-1:0] fifo_space,
  output logic [C_ADDR_WIDTH-1:0]       rd_offset,
  output logic                          busy,
  output logic                          err,
  circular_dma_reader_if.master         axi
);
  localparam int B     = C_AXIS_WIDTH / 8;
  localparam int LOG_B = $clog2(B);
  localparam logic [C_ADDR_WIDTH-1:0] MAX_BURST = C_ADDR_WIDTH'(C_MAX_BURST);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, SETTLE} state_t;
  state_t state_q, state_d;

  logic [C_ADDR_WIDTH-1:0] rd_offset_q;
  logic [C_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]              arlen_q;
  logic [8:0]              len_q;
  logic                    err_q;

  logic [C_ADDR_WIDTH-1:0] avail, to_wrap, to_4k, len_c, step, next_off;
  logic [11:0]             page_off;
  logic                    launch, r_fire, last_fire;

  // Burst sizing: never past available data, the buffer end or a 4 KB page.
  always_comb begin
    avail    = (wr_offset >= rd_offset_q) ? wr_offset - rd_offset_q
                                          : cfg_size - rd_offset_q + wr_offset;
    to_wrap  = cfg_size - rd_offset_q;
    page_off = cfg_base[11:0] + rd_offset_q[11:0];
    to_4k    = C_ADDR_WIDTH'(13'h1000 - {1'b0, page_off});
    len_c    = MAX_BURST;
    if ((avail >> LOG_B) < len_c)   len_c = avail >> LOG_B;
    if ((to_wrap >> LOG_B) < len_c) len_c = to_wrap >> LOG_B;
    if ((to_4k >> LOG_B) < len_c)   len_c = to_4k >> LOG_B;
  end

  assign launch    = cfg_enable && (avail != '0) && (C_ADDR_WIDTH'(fifo_space) >= len_c);
  assign r_fire    = (state_q == DATA) && axi.m_axi_rvalid && axi.m_axis_tready;
  assign last_fire = r_fire && axi.m_axi_rlast;
  assign step      = C_ADDR_WIDTH'(len_q) << LOG_B;
  assign next_off  = (rd_offset_q + step == cfg_size) ? '0 : rd_offset_q + step;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    axi.m_axi_arvalid  = 1'b0;
    axi.m_axi_rready   = 1'b0;
    axi.m_axis_tvalid  = 1'b0;
    case (state_q)
      IDLE:   if (launch) state_d = ADDR;
      ADDR: begin
        axi.m_axi_arvalid = 1'b1;
        if (axi.m_axi_arready) state_d = DATA;
      end
      DATA: begin
        axi.m_axis_tvalid = axi.m_axi_rvalid;
        axi.m_axi_rready  = axi.m_axis_tready;
        if (last_fire) state_d = SETTLE;
      end
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Offset commits only at burst end, so the IDLE comparison never sees a half-done burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_offset_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (!cfg_enable) begin
          rd_offset_q <= '0;
        end else if (launch) begin
          araddr_q <= cfg_base + rd_offset_q;
          arlen_q  <= 8'(len_c - 1'b1);
          len_q    <= 9'(len_c);
        end
      end
      if (r_fire && (axi.m_axi_rresp != 2'b00)) err_q <= 1'b1;
      if (last_fire) rd_offset_q <= next_off;
    end
  end

  assign axi.m_axi_araddr  = araddr_q;
  assign axi.m_axi_arlen   = arlen_q;
  assign axi.m_axi_arsize  = 3'(LOG_B);
  assign axi.m_axi_arburst = 2'b01;
  assign axi.m_axis_tdata  = axi.m_axi_rdata;
  assign axi.m_axis_tlast  = axi.m_axi_rlast;

  assign rd_offset = rd_offset_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
endmodule

// File: tb/tb_circular_dma_reader.sv
// Bench for circular_dma_reader: memory slave returning address-pattern data, a ring-buffer model
// checked every cycle, and directed scenarios with hand-computed burst lists.
`timescale 1ns/1ps
module tb_circular_dma_reader;
  localparam int AW = 32;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b1;
  logic [31:0] cfg_base = 32'h1000_0000;
  logic [31:0] cfg_size = 32'h0000_0400;
  logic [31:0] wr_offset = 32'h0;
  logic [15:0] fifo_space = 16'd64;
  logic [31:0] rd_offset;
  logic        busy, err;

  circular_dma_reader_if #(.C_ADDR_WIDTH(AW), .C_AXIS_WIDTH(DW)) axi ();

  circular_dma_reader #(
    .C_ADDR_WIDTH(AW), .C_AXIS_WIDTH(DW), .C_MAX_BURST(16), .C_FIFO_SPACE_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_base(cfg_base), .cfg_size(cfg_size),
    .wr_offset(wr_offset), .fifo_space(fifo_space), .rd_offset(rd_offset), .busy(busy),
    .err(err), .axi(axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_ADDR, M_DATA, M_SETTLE} mph_t;
  mph_t        ph = M_IDLE;
  logic [31:0] m_rd = 0, m_addr = 0;
  int          m_len = 0, m_beat = 0;
  logic        m_err = 0;
  bit          chk_en = 0;

  bit          ar_fire_n = 0, r_fire_n = 0, arvalid_n = 0;
  logic [31:0] araddr_n = 0;
  logic [7:0]  arlen_n = 0;
  logic [39:0] ar_log[$];
  int          beats = 0, tlasts = 0, arv_cycles = 0;
  int          ar_delay = 0, ar_cnt = 0;
  logic [31:0] bad_addr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Model of the ring buffer: decides per cycle what the DUT must be doing next.
  initial begin : compare
    int a, b, c, n;
    forever begin
      @(negedge clk);
      ar_fire_n = axi.m_axi_arvalid && axi.m_axi_arready;
      r_fire_n  = axi.m_axi_rvalid && axi.m_axi_rready;
      arvalid_n = axi.m_axi_arvalid;
      araddr_n  = axi.m_axi_araddr;
      arlen_n   = axi.m_axi_arlen;
      if (chk_en) begin
        chk("arvalid", 64'(axi.m_axi_arvalid), 64'(ph == M_ADDR));
        chk("busy", 64'(busy), 64'(ph != M_IDLE));
        chk("rready", 64'(axi.m_axi_rready), 64'(ph == M_DATA && axi.m_axis_tready));
        chk("tvalid", 64'(axi.m_axis_tvalid), 64'(ph == M_DATA && axi.m_axi_rvalid));
        chk("rd_offset", 64'(rd_offset), 64'(m_rd));
        chk("err", 64'(err), 64'(m_err));
        if (ph == M_ADDR) begin
          chk("araddr", 64'(axi.m_axi_araddr), 64'(m_addr));
          chk("arlen", 64'(axi.m_axi_arlen), 64'(m_len - 1));
        end
      end
      if (axi.m_axi_arvalid) arv_cycles++;
      if (ar_fire_n) ar_log.push_back({axi.m_axi_araddr, axi.m_axi_arlen});
      if (axi.m_axis_tvalid && axi.m_axis_tready) begin
        beats++;
        if (axi.m_axis_tlast) tlasts++;
      end
      if (rst) begin
        ph = M_IDLE; m_rd = 0; m_err = 0; m_beat = 0;
      end else begin
        case (ph)
          M_IDLE: begin
            if (!cfg_enable) m_rd = 0;
            else begin
              a = int'(((wr_offset + cfg_size - m_rd) % cfg_size) / 8);
              b = int'((cfg_size - m_rd) / 8);
              c = int'((32'd4096 - ((cfg_base + m_rd) % 32'd4096)) / 8);
              n = 16;
              if (a < n) n = a;
              if (b < n) n = b;
              if (c < n) n = c;
              if (a > 0 && int'(fifo_space) >= n) begin
                m_addr = cfg_base + m_rd; m_len = n; m_beat = 0; ph = M_ADDR;
              end
            end
          end
          M_ADDR: if (axi.m_axi_arready) ph = M_DATA;
          M_DATA: if (axi.m_axi_rvalid && axi.m_axis_tready) begin
            if (chk_en) begin
              chk("tdata", axi.m_axis_tdata, {32'h0, m_addr + 32'(8 * m_beat)});
              chk("tlast", 64'(axi.m_axis_tlast), 64'(m_beat == m_len - 1));
            end
            if (axi.m_axi_rresp != 2'b00) m_err = 1;
            m_beat++;
            if (m_beat == m_len) begin
              m_rd = (m_rd + 32'(8 * m_len)) % cfg_size;
              ph = M_SETTLE;
            end
          end
          default: ph = M_IDLE;
        endcase
      end
    end
  end

  // Memory slave: one burst at a time, data = byte address of the beat.
  initial begin : slave
    logic [31:0] s_addr;
    int s_len, s_beat;
    bit s_act;
    s_addr = 0; s_len = 0; s_beat = 0; s_act = 0;
    axi.m_axi_arready = 1'b1; axi.m_axi_rvalid = 1'b0; axi.m_axi_rdata = '0;
    axi.m_axi_rresp = 2'b00; axi.m_axi_rlast = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        s_act = 0; ar_cnt = 0;
      end else begin
        if (r_fire_n && s_act) begin
          s_beat++;
          if (s_beat == s_len) s_act = 0;
        end
        if (ar_fire_n) begin
          s_addr = araddr_n; s_len = int'(arlen_n) + 1; s_beat = 0; s_act = 1; ar_cnt = 0;
        end else if (arvalid_n) ar_cnt++;
      end
      axi.m_axi_arready = (ar_cnt >= ar_delay);
      axi.m_axi_rvalid  = s_act;
      axi.m_axi_rdata   = {32'h0, s_addr + 32'(8 * s_beat)};
      axi.m_axi_rlast   = s_act && (s_beat == s_len - 1);
      axi.m_axi_rresp   = (s_act && (s_addr + 32'(8 * s_beat)) == bad_addr) ? 2'b10 : 2'b00;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input logic [31:0] target, input int budget, input string name);
    int i = 0;
    while (!(ph == M_IDLE && rd_offset == target) && i < budget) begin step(1); i++; end
    chk({name, "_timeout"}, 64'(i < budget), 64'd1);
  endtask

  task automatic wait_ph(input mph_t target, input int budget, input string name);
    int i = 0;
    while (ph != target && i < budget) begin step(1); i++; end
    chk({name, "_timeout"}, 64'(i < budget), 64'd1);
  endtask

  initial begin : main
    axi.m_axis_tready = 1'b1;
    step(3);
    chk_en = 1;
    chk("rst_rd_offset", 64'(rd_offset), 64'd0);
    chk("rst_araddr", 64'(axi.m_axi_araddr), 64'd0);
    chk("rst_arlen", 64'(axi.m_axi_arlen), 64'd0);
    chk("rst_arvalid", 64'(axi.m_axi_arvalid), 64'd0);
    chk("rst_rready", 64'(axi.m_axi_rready), 64'd0);
    chk("rst_tvalid", 64'(axi.m_axis_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // 1: two full bursts then quiet
    ar_log.delete(); beats = 0; tlasts = 0;
    wr_offset = 32'h100; rst = 1'b0;
    wait_done(32'h100, 400, "t1");
    step(20);
    chk("t1_ar_count", 64'(ar_log.size()), 64'd2);
    chk("t1_ar0", 64'(ar_log[0]), {24'h0, 32'h1000_0000, 8'd15});
    chk("t1_ar1", 64'(ar_log[1]), {24'h0, 32'h1000_0080, 8'd15});
    chk("t1_beats", 64'(beats), 64'd32);
    chk("t1_tlasts", 64'(tlasts), 64'd2);
    chk("t1_rd", 64'(rd_offset), 64'h100);
    chk("t1_arsize", 64'(axi.m_axi_arsize), 64'd3);
    chk("t1_arburst", 64'(axi.m_axi_arburst), 64'd1);

    // 2: advance to 0x3C0, then wrap through the buffer end
    wr_offset = 32'h3C0;
    wait_done(32'h3C0, 1000, "t2a");
    ar_log.delete();
    wr_offset = 32'h40;
    wait_done(32'h40, 400, "t2b");
    chk("t2_ar_count", 64'(ar_log.size()), 64'd2);
    chk("t2_ar0", 64'(ar_log[0]), {24'h0, 32'h1000_03C0, 8'd7});
    chk("t2_ar1", 64'(ar_log[1]), {24'h0, 32'h1000_0000, 8'd7});

    // 3: insufficient downstream space holds off the burst
    ar_log.delete();
    fifo_space = 16'd8; wr_offset = 32'h140;
    step(20);
    chk("t3_no_ar", 64'(ar_log.size()), 64'd0);
    chk("t3_idle", 64'(busy), 64'd0);
    fifo_space = 16'd16;
    wait_done(32'h140, 400, "t3");
    chk("t3_ar_count", 64'(ar_log.size()), 64'd2);
    chk("t3_ar0", 64'(ar_log[0]), {24'h0, 32'h1000_0040, 8'd15});

    // 4: slow arready and toggling tready
    ar_delay = 5; step(1);
    ar_log.delete(); arv_cycles = 0; beats = 0;
    wr_offset = 32'h1C0;
    begin
      int i = 0;
      while (!(ph == M_IDLE && rd_offset == 32'h1C0) && i < 300) begin
        step(1); axi.m_axis_tready = ~axi.m_axis_tready; i++;
      end
      chk("t4_timeout", 64'(i < 300), 64'd1);
    end
    axi.m_axis_tready = 1'b1; ar_delay = 0;
    chk("t4_arvalid_cycles", 64'(arv_cycles), 64'd6);
    chk("t4_beats", 64'(beats), 64'd16);
    chk("t4_ar0", 64'(ar_log[0]), {24'h0, 32'h1000_0140, 8'd15});

    // 5: SLVERR on beat 3 is sticky, data still delivered
    bad_addr = 32'h1000_01D0; beats = 0;
    wr_offset = 32'h240;
    wait_done(32'h240, 400, "t5");
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_beats", 64'(beats), 64'd16);
    step(10);
    chk("t5_err_sticky", 64'(err), 64'd1);
    bad_addr = 32'h0;
    rst = 1'b1; wr_offset = 32'h100;
    step(2);
    chk("t5_err_cleared", 64'(err), 64'd0);
    chk("t5_rd_cleared", 64'(rd_offset), 64'd0);
    rst = 1'b0;

    // 6: enable dropped mid-burst, then reset mid-burst
    wait_ph(M_DATA, 50, "t6a");
    step(2);
    cfg_enable = 1'b0;
    wait_ph(M_SETTLE, 100, "t6b");
    chk("t6_commit", 64'(rd_offset), 64'h80);
    step(3);
    chk("t6_cleared", 64'(rd_offset), 64'd0);
    chk("t6_idle", 64'(busy), 64'd0);
    cfg_enable = 1'b1;
    wait_ph(M_DATA, 50, "t6c");
    step(3);
    rst = 1'b1;
    step(1);
    chk("t6_rst_arvalid", 64'(axi.m_axi_arvalid), 64'd0);
    chk("t6_rst_tvalid", 64'(axi.m_axis_tvalid), 64'd0);
    chk("t6_rst_rready", 64'(axi.m_axi_rready), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rd", 64'(rd_offset), 64'd0);
    step(1);
    rst = 1'b0;
    wait_done(32'h100, 400, "t6d");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
